mem_access: RTL and testbench
=============================

# mem_access

Data-memory access stage of the core pipeline, placed directly after the execute stage. It consumes the execute stage's load request (`MEM_R_*`) and store request (`MEM_W_*`) and issues them on a ready/valid data-memory bus. It holds the pipeline with `STALL` while a transaction is outstanding. Loaded data is extracted by byte lane, sign- or zero-extended, and presented as a one-cycle register write-back.

## Interface
- `TIMEOUT_CYCLES`, default 255: maximum cycles spent in CMD+RESP before the transaction is aborted; range 1..65535.
- `CLK` in 1: clock; all logic is on the rising edge.
- `RST` in 1: reset, synchronous, active-high.
- `MEM_R_VALID` in 1: load request from execute.
- `MEM_R_RD` in 5: load destination register; 0 means discard the result.
- `MEM_R_ADDR` in 32: word-aligned load address.
- `MEM_R_STRB` in 4: byte lanes to load.
- `MEM_R_SIGNED` in 1: 1 selects sign-extension, 0 selects zero-extension.
- `MEM_W_VALID` in 1: store request from execute.
- `MEM_W_ADDR` in 32: word-aligned store address.
- `MEM_W_STRB` in 4: byte lanes to store.
- `MEM_W_DATA` in 32: store data, already lane-shifted.
- `STALL` out 1: freezes the upstream pipeline registers.
- `REG_W_RD` out 5: load write-back destination; 0 means no write.
- `REG_W_DATA` out 32: load write-back value.
- `MEM_ERR` out 1: one-cycle pulse when a transaction times out.
- `DMEM_CMD_VALID` out 1: bus command valid.
- `DMEM_CMD_READY` in 1: bus command accepted.
- `DMEM_CMD_WE` out 1: 1 = write, 0 = read.
- `DMEM_CMD_ADDR` out 32: bus address.
- `DMEM_CMD_STRB` out 4: bus byte enables.
- `DMEM_CMD_WDATA` out 32: bus write data.
- `DMEM_RESP_VALID` in 1: read data valid.
- `DMEM_RESP_DATA` in 32: read data.

## Operation
- FSM states: IDLE, CMD, RESP, DONE.
- **IDLE**
  - If `MEM_W_VALID`=1, capture the store and go to CMD. `MEM_R_VALID` in the same cycle is ignored: stores take priority, and the read that execute emits alongside a store is dropped.
  - Else if `MEM_R_VALID`=1, capture the load (including `MEM_R_RD` and `MEM_R_SIGNED`) and go to CMD.
- **CMD**
  - `DMEM_CMD_VALID`=1 with the captured address, strobe, data and WE.
  - On `DMEM_CMD_READY`=1: a store goes to DONE; a load goes to RESP.
- **RESP**
  - On `DMEM_RESP_VALID`=1: capture the extracted data and go to DONE.
  - `DMEM_RESP_VALID` is ignored in every state other than RESP.
- **DONE**
  - Lasts one cycle. Inputs are ignored in this state, so the still-presented request is not recaptured. Next state is IDLE.
- **STALL**, combinational:
  - 1 in IDLE when `MEM_R_VALID` or `MEM_W_VALID` is 1.
  - 1 in CMD and RESP.
  - 0 in DONE.
- **Load extraction**
  - k = index of the lowest set bit of the captured strobe; n = number of set bits.
  - v = `DMEM_RESP_DATA` >> 8k.
  - n=1: byte v[7:0]. n=2: half v[15:0]. n=4: word v. n=0: value 0.
  - Any other n uses the width of the highest power of two ≤ n.
  - For byte and half, `SIGNED`=1 replicates the top bit of the extracted field; otherwise zero-fill.
  - A half-load strobe of 1000 (offset 3) yields a byte. No trap is raised.
- **Write-back**
  - In DONE after a load: `REG_W_RD` = captured rd and `REG_W_DATA` = extracted value.
  - All other cycles: both are 0.
  - A store never writes back.
- **Timeout**
  - A 16-bit counter clears on leaving IDLE and increments each cycle in CMD or RESP.
  - On reaching `TIMEOUT_CYCLES`: drop `DMEM_CMD_VALID`, go to DONE, and pulse `MEM_ERR`.
  - An aborted load writes back rd with data 0.
  - A response arriving after an abort is ignored.
- **Reset**
  - All outputs and the state are registered to 0 / IDLE.
  - `RST` asserted mid-transaction abandons it: `DMEM_CMD_VALID`=0 and `STALL`=0 from the next cycle.
  - The bus side is responsible for discarding any in-flight response.

## Timing
- All outputs are registered except `STALL`.
- Request seen at cycle 0 gives `DMEM_CMD_VALID` from cycle 1.
- Bus stall rule: `DMEM_CMD_*` stay stable while `DMEM_CMD_VALID`=1 and `DMEM_CMD_READY`=0. The only exception is a timeout abort.
- Store with `READY`=1: accepted at cycle 1, DONE at cycle 2.
- Load with `READY`=1 and the response one cycle after acceptance: `RESP_VALID` at cycle 2, write-back visible at cycle 3.
- The pipeline advances on the DONE-cycle edge. Back-to-back requests are therefore spaced by at least 3 cycles (store) or 4 cycles (load).
- A response arriving in the same cycle as acceptance is not possible: RESP is entered only after acceptance.

## Test plan
- **lw, zero-wait bus:** `ADDR`=0x100, `STRB`=1111; resp 0xDEADBEEF at cycle 2 -> cycle 3 `REG_W_RD`=rd, `REG_W_DATA`=0xDEADBEEF; `STALL`=1 for cycles 0-2.
- **lb at offset 2:** `STRB`=0100, `SIGNED`=1, resp 0x00800000 -> 0xFFFFFF80. Same with `SIGNED`=0 -> 0x00000080. lhu with `STRB`=1100, resp 0xBEEF0000 -> 0x0000BEEF.
- **sb with simultaneous read:** `MEM_W_VALID`=`MEM_R_VALID`=1, `STRB`=0010, `DATA`=0x0000AB00 -> exactly one command with `WE`=1, `STRB`=0010, `WDATA`=0x0000AB00; no write-back; `STALL` released at cycle 2.
- **Back-pressure:** `READY` held low 5 cycles -> command fields stable throughout; `STALL` held; accepted on cycle 6; no duplicate command.
- **Timeout:** `TIMEOUT_CYCLES`=4, load, `READY` accepted, no response -> `MEM_ERR` pulses once, write-back rd with 0x0; a late `RESP_VALID` is ignored.
- **Reset in RESP:** `RST` asserted -> next cycle all outputs 0 and state IDLE; a following lw completes normally.

Source files
------------

// File: rtl/mem_access_if.sv
// Ready/valid data-memory bus between the memory-access stage (master)
// and the data memory (slave).
interface mem_access_if;
    logic        DMEM_CMD_VALID;
    logic        DMEM_CMD_READY;
    logic        DMEM_CMD_WE;
    logic [31:0] DMEM_CMD_ADDR;
    logic [3:0]  DMEM_CMD_STRB;
    logic [31:0] DMEM_CMD_WDATA;
    logic        DMEM_RESP_VALID;
    logic [31:0] DMEM_RESP_DATA;

    modport master (
        output DMEM_CMD_VALID, DMEM_CMD_WE, DMEM_CMD_ADDR, DMEM_CMD_STRB, DMEM_CMD_WDATA,
        input  DMEM_CMD_READY, DMEM_RESP_VALID, DMEM_RESP_DATA
    );

    modport slave (
        input  DMEM_CMD_VALID, DMEM_CMD_WE, DMEM_CMD_ADDR, DMEM_CMD_STRB, DMEM_CMD_WDATA,
        output DMEM_CMD_READY, DMEM_RESP_VALID, DMEM_RESP_DATA
    );
endinterface

// File: rtl/mem_access.sv
// Data-memory access stage: issues execute-stage loads/stores on the dmem bus,
// stalls the pipeline while busy, and returns extended load data as a write-back.
module mem_access #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         MEM_R_VALID,
    input  logic [4:0]   MEM_R_RD,
    input  logic [31:0]  MEM_R_ADDR,
    input  logic [3:0]   MEM_R_STRB,
    input  logic         MEM_R_SIGNED,
    input  logic         MEM_W_VALID,
    input  logic [31:0]  MEM_W_ADDR,
    input  logic [3:0]   MEM_W_STRB,
    input  logic [31:0]  MEM_W_DATA,
    output logic         STALL,
    output logic [4:0]   REG_W_RD,
    output logic [31:0]  REG_W_DATA,
    output logic         MEM_ERR,
    mem_access_if.master dmem
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state_r, state_nxt_s;
    logic        cmd_valid_r, we_r, signed_r, err_r;
    logic [31:0] addr_r, wdata_r, reg_data_r;
    logic [3:0]  strb_r;
    logic [4:0]  rd_r, reg_rd_r;
    logic [15:0] cnt_r, cnt_inc_s;
    logic        timeout_s, stall_s, take_w_s, take_r_s, accept_s, resp_hit_s, abort_s;

    // Lane extraction: shift the lowest enabled lane down, width is the
    // largest power of two not above the number of enabled lanes.
    function automatic logic [31:0] extract_load(input logic [3:0] strb,
                                                 input logic [31:0] data,
                                                 input logic sgn);
        logic [31:0] v;
        logic [31:0] res;
        logic [2:0]  n;
        logic [1:0]  k;
        logic        found;
        n     = 3'd0;
        k     = 2'd0;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) begin
                n = n + 3'd1;
                if (!found) begin
                    k     = 2'(i);
                    found = 1'b1;
                end
            end
        end
        v = data >> {k, 3'b000};
        case (n)
            3'd1:       res = sgn ? {{24{v[7]}}, v[7:0]}   : {24'd0, v[7:0]};
            3'd2, 3'd3: res = sgn ? {{16{v[15]}}, v[15:0]} : {16'd0, v[15:0]};
            3'd4:       res = v;
            default:    res = 32'd0;
        endcase
        return res;
    endfunction

    assign cnt_inc_s = cnt_r + 16'd1;
    assign timeout_s = (cnt_inc_s >= 16'(TIMEOUT_CYCLES));

    // Next-state decode, stall and per-cycle event strobes; a completing
    // handshake wins over a timeout in the same cycle.
    always_comb begin
        state_nxt_s = state_r;
        stall_s     = 1'b0;
        take_w_s    = 1'b0;
        take_r_s    = 1'b0;
        accept_s    = 1'b0;
        resp_hit_s  = 1'b0;
        abort_s     = 1'b0;
        case (state_r)
            IDLE: begin
                stall_s = MEM_R_VALID | MEM_W_VALID;
                if (MEM_W_VALID) begin
                    take_w_s    = 1'b1;
                    state_nxt_s = CMD;
                end else if (MEM_R_VALID) begin
                    take_r_s    = 1'b1;
                    state_nxt_s = CMD;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            CMD: begin
                stall_s = 1'b1;
                if (dmem.DMEM_CMD_READY) begin
                    accept_s    = 1'b1;
                    state_nxt_s = we_r ? DONE : RESP;
                end else if (timeout_s) begin
                    abort_s     = 1'b1;
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = CMD;
                end
            end
            RESP: begin
                stall_s = 1'b1;
                if (dmem.DMEM_RESP_VALID) begin
                    resp_hit_s  = 1'b1;
                    state_nxt_s = DONE;
                end else if (timeout_s) begin
                    abort_s     = 1'b1;
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = RESP;
                end
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // State, captured request, timeout counter and registered outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r     <= IDLE;
            cmd_valid_r <= 1'b0;
            we_r        <= 1'b0;
            signed_r    <= 1'b0;
            addr_r      <= 32'd0;
            strb_r      <= 4'd0;
            wdata_r     <= 32'd0;
            rd_r        <= 5'd0;
            cnt_r       <= 16'd0;
            reg_rd_r    <= 5'd0;
            reg_data_r  <= 32'd0;
            err_r       <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            err_r      <= abort_s;
            reg_rd_r   <= 5'd0;
            reg_data_r <= 32'd0;
            if (take_w_s) begin
                cmd_valid_r <= 1'b1;
                we_r        <= 1'b1;
                addr_r      <= MEM_W_ADDR;
                strb_r      <= MEM_W_STRB;
                wdata_r     <= MEM_W_DATA;
                rd_r        <= 5'd0;
                signed_r    <= 1'b0;
                cnt_r       <= 16'd0;
            end else if (take_r_s) begin
                cmd_valid_r <= 1'b1;
                we_r        <= 1'b0;
                addr_r      <= MEM_R_ADDR;
                strb_r      <= MEM_R_STRB;
                wdata_r     <= 32'd0;
                rd_r        <= MEM_R_RD;
                signed_r    <= MEM_R_SIGNED;
                cnt_r       <= 16'd0;
            end else begin
                if (accept_s || abort_s) begin
                    cmd_valid_r <= 1'b0;
                end
                if (state_r == CMD || state_r == RESP) begin
                    cnt_r <= cnt_inc_s;
                end
            end
            if (resp_hit_s) begin
                reg_rd_r   <= rd_r;
                reg_data_r <= extract_load(strb_r, dmem.DMEM_RESP_DATA, signed_r);
            end else if (abort_s && !we_r) begin
                reg_rd_r   <= rd_r;
                reg_data_r <= 32'd0;
            end
        end
    end

    assign STALL               = stall_s;
    assign REG_W_RD            = reg_rd_r;
    assign REG_W_DATA          = reg_data_r;
    assign MEM_ERR             = err_r;
    assign dmem.DMEM_CMD_VALID = cmd_valid_r;
    assign dmem.DMEM_CMD_WE    = we_r;
    assign dmem.DMEM_CMD_ADDR  = addr_r;
    assign dmem.DMEM_CMD_STRB  = strb_r;
    assign dmem.DMEM_CMD_WDATA = wdata_r;

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: directed and random load/store transactions checked
// cycle by cycle against a timeline computed from the stage's access rules.
module tb_mem_access;
    localparam int TMO = 8;

    logic        clk;
    logic        rst;
    logic        r_valid, r_signed, w_valid;
    logic [4:0]  r_rd;
    logic [31:0] r_addr, w_addr, w_data;
    logic [3:0]  r_strb, w_strb;
    logic        stall, mem_err;
    logic [4:0]  reg_rd;
    logic [31:0] reg_data;
    int          total;
    int          bad;

    mem_access_if bus ();

    mem_access #(.TIMEOUT_CYCLES(TMO)) dut (
        .CLK          (clk),
        .RST          (rst),
        .MEM_R_VALID  (r_valid),
        .MEM_R_RD     (r_rd),
        .MEM_R_ADDR   (r_addr),
        .MEM_R_STRB   (r_strb),
        .MEM_R_SIGNED (r_signed),
        .MEM_W_VALID  (w_valid),
        .MEM_W_ADDR   (w_addr),
        .MEM_W_STRB   (w_strb),
        .MEM_W_DATA   (w_data),
        .STALL        (stall),
        .REG_W_RD     (reg_rd),
        .REG_W_DATA   (reg_data),
        .MEM_ERR      (mem_err),
        .dmem         (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference load value: lowest enabled lane, width = largest power of two <= lane count.
    function automatic logic [31:0] ref_load(input logic [3:0] strb, input logic [31:0] data,
                                             input logic sgn);
        int n;
        int k;
        int w;
        logic [31:0] v;
        logic [31:0] mask;
        n = $countones(strb);
        if (n == 0) return 32'd0;
        k = 0;
        while (!strb[k]) k++;
        v = data >> (8 * k);
        w = (n >= 4) ? 32 : ((n >= 2) ? 16 : 8);
        if (w == 32) return v;
        mask = (32'd1 << w) - 32'd1;
        v = v & mask;
        if (sgn && v[w-1]) v = v | ~mask;
        return v;
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_stall"}, {31'd0, stall}, 32'd0);
        check({tag, "_cmd_valid"}, {31'd0, bus.DMEM_CMD_VALID}, 32'd0);
        check({tag, "_rd"}, {27'd0, reg_rd}, 32'd0);
        check({tag, "_data"}, reg_data, 32'd0);
        check({tag, "_err"}, {31'd0, mem_err}, 32'd0);
    endtask

    // One transaction: request at cycle 0; ready after d_ready CMD cycles, response
    // d_resp cycles after acceptance (-1 = never); checks every cycle through done+1.
    task automatic run_txn(input string tag, input bit is_st, input bit rd_also,
                           input logic [4:0] rd, input logic [31:0] addr,
                           input logic [3:0] strb, input logic [31:0] wdata,
                           input bit sgn, input int d_ready, input int d_resp,
                           input logic [31:0] rdata, input bit late);
        int a;
        int r;
        int done;
        int cmd_last;
        bit err;
        bit in_resp;
        logic [31:0] ext;
        a   = (d_ready < 0) ? -1 : 1 + d_ready;
        r   = (is_st || a < 0 || d_resp < 0) ? -1 : a + 1 + d_resp;
        err = 1'b0;
        if (a < 0) begin
            done = TMO + 1;
            err  = 1'b1;
        end else if (is_st) begin
            done = a + 1;
        end else if (r < 0 || r > TMO) begin
            done = TMO + 1;
            err  = 1'b1;
        end else begin
            done = r + 1;
        end
        cmd_last = (a < 0) ? TMO : a;
        ext      = ref_load(strb, rdata, sgn);

        w_valid  = is_st;
        r_valid  = !is_st || rd_also;
        w_addr   = is_st ? addr : $urandom;
        w_strb   = is_st ? strb : 4'($urandom);
        w_data   = is_st ? wdata : $urandom;
        r_addr   = is_st ? $urandom : addr;
        r_strb   = is_st ? 4'($urandom) : strb;
        r_rd     = is_st ? 5'($urandom) : rd;
        r_signed = is_st ? 1'($urandom) : sgn;

        for (int c = 0; c <= done + 1; c++) begin
            if (c == done + 1) begin
                w_valid = 1'b0;
                r_valid = 1'b0;
            end
            in_resp = !is_st && a >= 0 && c > a && c < done;
            bus.DMEM_CMD_READY  = (a >= 0 && c == a);
            if (in_resp) begin
                bus.DMEM_RESP_VALID = (c == r);
                bus.DMEM_RESP_DATA  = (c == r) ? rdata : $urandom;
            end else begin
                bus.DMEM_RESP_VALID = (late && c == done + 1) ? 1'b1 : 1'($urandom);
                bus.DMEM_RESP_DATA  = $urandom;
            end
            #1;
            check($sformatf("%s_c%0d_stall", tag, c), {31'd0, stall}, {31'd0, (c < done)});
            check($sformatf("%s_c%0d_cmd_valid", tag, c), {31'd0, bus.DMEM_CMD_VALID},
                  {31'd0, (c >= 1 && c <= cmd_last)});
            if (c >= 1 && c <= cmd_last) begin
                check($sformatf("%s_c%0d_we", tag, c), {31'd0, bus.DMEM_CMD_WE}, {31'd0, is_st});
                check($sformatf("%s_c%0d_addr", tag, c), bus.DMEM_CMD_ADDR, addr);
                check($sformatf("%s_c%0d_strb", tag, c), {28'd0, bus.DMEM_CMD_STRB}, {28'd0, strb});
                if (is_st) check($sformatf("%s_c%0d_wdata", tag, c), bus.DMEM_CMD_WDATA, wdata);
            end
            check($sformatf("%s_c%0d_rd", tag, c), {27'd0, reg_rd},
                  (!is_st && c == done) ? {27'd0, rd} : 32'd0);
            check($sformatf("%s_c%0d_data", tag, c), reg_data,
                  (!is_st && c == done && !err) ? ext : 32'd0);
            check($sformatf("%s_c%0d_err", tag, c), {31'd0, mem_err}, {31'd0, (c == done && err)});
            tick();
        end
        bus.DMEM_CMD_READY  = 1'b0;
        bus.DMEM_RESP_VALID = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst = 1'b1;
        r_valid = 1'b0; r_signed = 1'b0; w_valid = 1'b0;
        r_rd = 5'd0; r_addr = 32'd0; r_strb = 4'd0;
        w_addr = 32'd0; w_strb = 4'd0; w_data = 32'd0;
        bus.DMEM_CMD_READY = 1'b0; bus.DMEM_RESP_VALID = 1'b0; bus.DMEM_RESP_DATA = 32'd0;
        tick();
        tick();
        check_idle("reset");
        rst = 1'b0;
        tick();

        run_txn("lw",       0, 0, 5'd5,  32'h100, 4'b1111, 32'd0, 0,  0,  0, 32'hDEADBEEF, 0);
        run_txn("lb_s",     0, 0, 5'd6,  32'h204, 4'b0100, 32'd0, 1,  0,  0, 32'h00800000, 0);
        run_txn("lbu",      0, 0, 5'd7,  32'h204, 4'b0100, 32'd0, 0,  0,  0, 32'h00800000, 0);
        run_txn("lhu",      0, 0, 5'd8,  32'h208, 4'b1100, 32'd0, 0,  0,  0, 32'hBEEF0000, 0);
        run_txn("lh_off3",  0, 0, 5'd9,  32'h20C, 4'b1000, 32'd0, 1,  1,  2, 32'h80000000, 0);
        run_txn("l_nostrb", 0, 0, 5'd10, 32'h210, 4'b0000, 32'd0, 1,  0,  1, 32'hFFFFFFFF, 0);
        run_txn("l_3lane",  0, 0, 5'd11, 32'h214, 4'b1110, 32'd0, 1,  0,  0, 32'h12F45600, 0);
        run_txn("sb_rd",    1, 1, 5'd12, 32'h300, 4'b0010, 32'h0000AB00, 0, 0, 0, 32'd0, 0);
        run_txn("bp",       1, 0, 5'd0,  32'h304, 4'b1111, 32'hCAFEF00D, 0, 5, 0, 32'd0, 0);
        run_txn("bp_ld",    0, 0, 5'd13, 32'h308, 4'b0011, 32'd0, 1,  5,  0, 32'h0000F00D, 0);
        run_txn("tmo_ld",   0, 0, 5'd14, 32'h400, 4'b1111, 32'd0, 0,  0, -1, 32'h11111111, 1);
        run_txn("tmo_st",   1, 0, 5'd0,  32'h404, 4'b1111, 32'h55AA55AA, 0, -1, 0, 32'd0, 0);

        // Reset while a load waits in RESP, then a normal load.
        r_valid = 1'b1; r_rd = 5'd3; r_addr = 32'h500; r_strb = 4'b1111; r_signed = 1'b0;
        tick();
        bus.DMEM_CMD_READY = 1'b1;
        tick();
        bus.DMEM_CMD_READY = 1'b0;
        #1;
        check("rst_resp_stall", {31'd0, stall}, 32'd1);
        check("rst_resp_cmd_valid", {31'd0, bus.DMEM_CMD_VALID}, 32'd0);
        tick();
        rst = 1'b1;
        r_valid = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        check_idle("rst_mid");
        tick();
        run_txn("lw_after_rst", 0, 0, 5'd3, 32'h504, 4'b1111, 32'd0, 0, 1, 1, 32'hA5A5_0F0F, 0);

        for (int i = 0; i < 40; i++) begin
            bit          st;
            int          dr;
            int          dp;
            st = 1'($urandom);
            dr = int'($urandom_range(0, 3));
            dp = int'($urandom_range(0, 2));
            if ($urandom_range(0, 7) == 0) dr = -1;
            if ($urandom_range(0, 7) == 0) dp = -1;
            run_txn($sformatf("rnd%0d", i), st, 1'($urandom), 5'($urandom),
                    {$urandom, 2'b00} & 32'hFFFF_FFFC, 4'($urandom), $urandom,
                    1'($urandom), dr, dp, $urandom, 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
